// File: rtl/mem_access_unit.sv
// MEM-stage data memory access unit: launches one bus access per load/store,
// holds the pipeline until the access completes or times out, and formats load data.
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  DMType,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ready,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          lat_load;
    logic [2:0]    lat_type;
    logic [1:0]    lat_lane;

    logic          access;
    logic          is_word;
    logic          is_half;
    logic          bad_align;
    logic          legal;
    logic [3:0]    be_nxt;
    logic [31:0]   wdata_nxt;
    logic [15:0]   half_sel;
    logic [7:0]    byte_sel;
    logic [31:0]   load_fmt;

    always_comb begin
        access    = MemRead | MemWrite;
        is_word   = (DMType == 3'b000);
        is_half   = (DMType == 3'b001) || (DMType == 3'b010);
        bad_align = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
        legal     = access && !bad_align;
        if (is_word) begin
            be_nxt    = 4'b1111;
            wdata_nxt = wdata;
        end else if (is_half) begin
            be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_nxt = {2{wdata[15:0]}};
        end else begin
            be_nxt    = 4'b0001 << addr[1:0];
            wdata_nxt = {4{wdata[7:0]}};
        end
    end

    // Reset gates the combinational handshake so upstream sees no hold during rst.
    assign misalign = !rst && access && bad_align;
    assign stall    = !rst && (((state == IDLE) && legal) || (state == BUSY));

    always_comb begin
        half_sel = lat_lane[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (lat_lane)
            2'd0:    byte_sel = dm_rdata[7:0];
            2'd1:    byte_sel = dm_rdata[15:8];
            2'd2:    byte_sel = dm_rdata[23:16];
            default: byte_sel = dm_rdata[31:24];
        endcase
        case (lat_type)
            3'b000:  load_fmt = dm_rdata;
            3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_fmt = {16'h0000, half_sel};
            3'b011:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
            default: load_fmt = {24'h000000, byte_sel};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            dm_wdata  <= '0;
            dm_be     <= '0;
            read_data <= '0;
            bus_err   <= 1'b0;
            lat_load  <= 1'b0;
            lat_type  <= '0;
            lat_lane  <= '0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (legal) begin
                        state    <= BUSY;
                        cnt      <= '0;
                        dm_req   <= 1'b1;
                        dm_we    <= MemWrite;
                        dm_addr  <= {addr[31:2], 2'b00};
                        dm_be    <= be_nxt;
                        dm_wdata <= wdata_nxt;
                        lat_load <= !MemWrite;
                        lat_type <= DMType;
                        lat_lane <= addr[1:0];
                    end
                end
                BUSY: begin
                    // dm_ready wins over a simultaneous timeout.
                    if (dm_ready) begin
                        state  <= DONE;
                        dm_req <= 1'b0;
                        if (lat_load) begin
                            read_data <= load_fmt;
                        end
                    end else if (cnt == TMAX) begin
                        state   <= DONE;
                        dm_req  <= 1'b0;
                        bus_err <= 1'b1;
                        if (lat_load) begin
                            read_data <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
